vga_display_regbank: RTL and testbench

- Double-buffered 16x8 display register bank sitting directly upstream of the VGA central controller.
- Feeds its MemDataIN from the controller's 4-bit MemAddrOut.
- A producer (RTC/format logic) writes into a back bank and commits.
- Banks swap only at the start of vertical sync, so no frame shows a half-updated set of characters.

---
 rtl/vga_display_regbank.sv | 76 +++++++
 tb/tb_vga_display_regbank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_display_regbank.sv
// vga_display_regbank: double-buffered display register bank that swaps banks at vsync assertion
module vga_display_regbank #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic VSync,
  input  logic [$clog2(DEPTH)-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  input  logic WrEn,
  input  logic [$clog2(DEPTH)-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic Commit,
  output logic WrReady,
  output logic Pending,
  output logic SwapDone
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
  state_t state, next;
  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic front_sel, vs_q, vs_edge, we;
  logic [AW-1:0] cnt, wa;
  logic [DATA_W-1:0] wd;
  assign vs_edge = (VSync ^ VSYNC_ACTIVE_LOW) & ~(vs_q ^ VSYNC_ACTIVE_LOW);
  assign RdData = front_sel ? bank1[RdAddr] : bank0[RdAddr];
  assign WrReady = state == IDLE;
  assign Pending = state == PENDING;
  // next state: commit arms the swap, vsync assertion swaps, copy runs one pass over the bank
  always_comb begin
    next = (state == IDLE && Commit) ? PENDING :
           (state == PENDING && vs_edge) ? COPY :
           (state == COPY && cnt == LAST) ? IDLE : state;
  end
  // back-bank write port: producer writes while idle, resync copy from front while copying
  always_comb begin
    we = (state == IDLE && WrEn) || state == COPY;
    wa = state == COPY ? cnt : WrAddr;
    wd = state == COPY ? (front_sel ? bank1[cnt] : bank0[cnt]) : WrData;
  end
  // control state: fsm, bank select, copy counter, vsync sample and done pulse
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      front_sel <= 1'b0;
      cnt <= '0;
      vs_q <= VSYNC_ACTIVE_LOW;
      SwapDone <= 1'b0;
    end else begin
      state <= next;
      vs_q <= VSync;
      SwapDone <= state == COPY && cnt == LAST;
      if (state == PENDING && vs_edge) begin
        front_sel <= ~front_sel;
        cnt <= '0;
      end else if (state == COPY) cnt <= cnt + 1'b1;
    end
  end
  // storage: both banks cleared on reset, only the back bank is ever written
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= RESET_VALUE;
        bank1[i] <= RESET_VALUE;
      end
    end else if (we) begin
      if (front_sel) bank0[wa] <= wd;
      else bank1[wa] <= wd;
    end
  end
endmodule

// File: tb/tb_vga_display_regbank.sv
// tb_vga_display_regbank: randomized self-checking bench against a displayed/staged bank model
module tb_vga_display_regbank;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, wr_en = 1'b0, commit = 1'b0;
  logic [3:0] rd_addr = '0, wr_addr = '0;
  logic [7:0] wr_data = '0, rd_data;
  logic wr_ready, pending, swap_done;
  logic [7:0] disp [16];
  logic [7:0] staged [16];
  logic m_idle;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  vga_display_regbank dut (
    .CLK(clk), .RESET(rst_n), .VSync(vsync), .RdAddr(rd_addr), .RdData(rd_data),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .Commit(commit),
    .WrReady(wr_ready), .Pending(pending), .SwapDone(swap_done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      disp[i] = 8'h00;
      staged[i] = 8'h00;
    end
    m_idle = 1'b1;
  endtask
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic c);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    commit = c;
    tick();
    wr_en = 1'b0;
    commit = 1'b0;
    if (m_idle) begin
      staged[a] = d;
      if (c) m_idle = 1'b0;
    end
  endtask
  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_idle = 1'b0;
  endtask
  task automatic do_swap(output int lat);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (swap_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (!m_idle) begin
      disp = staged;
      m_idle = 1'b1;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      total++;
      if (rd_data !== 8'h00) $display("FAIL reset_rd[%0d] got %h exp 00", i, rd_data);
      else passed++;
    end
    total++;
    if ({wr_ready, pending, swap_done} !== 3'b100)
      $display("FAIL reset_flags got rdy/pend/done=%b exp 100", {wr_ready, pending, swap_done});
    else passed++;
  endtask
  task automatic test_write_no_commit();
    int pulses = 0;
    do_write(4'd5, 8'hA5, 1'b0);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    repeat (20) begin
      tick();
      if (swap_done === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL nocommit_swapdone got %0d pulses exp 0", pulses);
    else passed++;
    rd_addr = 4'd5;
    @(negedge clk);
    total++;
    if (rd_data !== 8'h00) $display("FAIL nocommit_rd5 got %h exp 00", rd_data);
    else passed++;
    total++;
    if ({wr_ready, pending} !== 2'b10) $display("FAIL nocommit_flags got %b exp 10", {wr_ready, pending});
    else passed++;
  endtask
  task automatic test_commit_swap();
    int n = 0;
    rd_addr = 4'd3;
    do_write(4'd3, 8'h33, 1'b1);
    @(negedge clk);
    total++;
    if ({wr_ready, pending} !== 2'b01) $display("FAIL commit_pending got rdy/pend=%b exp 01", {wr_ready, pending});
    else passed++;
    total++;
    if (rd_data !== disp[3]) $display("FAIL commit_preswap_rd3 got %h exp %h", rd_data, disp[3]);
    else passed++;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    disp = staged;
    m_idle = 1'b1;
    @(negedge clk);
    total++;
    if (rd_data !== 8'h33) $display("FAIL swap_rd3 got %h exp 33", rd_data);
    else passed++;
    total++;
    if ({wr_ready, pending} !== 2'b00) $display("FAIL swap_copy_flags got %b exp 00", {wr_ready, pending});
    else passed++;
    while (n < 40 && swap_done !== 1'b1) begin
      tick();
      n++;
    end
    total++;
    if (n !== 16) $display("FAIL swapdone_latency got %0d exp 16", n);
    else passed++;
    total++;
    if (wr_ready !== 1'b1) $display("FAIL swapdone_ready got %b exp 1", wr_ready);
    else passed++;
    tick();
    total++;
    if (swap_done !== 1'b0) $display("FAIL swapdone_width got %b exp 0", swap_done);
    else passed++;
  endtask
  task automatic test_mirror();
    int lat;
    do_write(4'd4, 8'h44, 1'b0);
    do_commit();
    do_swap(lat);
    total++;
    if (lat !== 16) $display("FAIL mirror_latency got %0d exp 16", lat);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      total++;
      if (rd_data !== disp[i]) $display("FAIL mirror_rd[%0d] got %h exp %h", i, rd_data, disp[i]);
      else passed++;
    end
    rd_addr = 4'd3;
    @(negedge clk);
    total++;
    if (rd_data !== 8'h33) $display("FAIL mirror_rd3 got %h exp 33", rd_data);
    else passed++;
    rd_addr = 4'd4;
    @(negedge clk);
    total++;
    if (rd_data !== 8'h44) $display("FAIL mirror_rd4 got %h exp 44", rd_data);
    else passed++;
  endtask
  task automatic test_blocked_and_held_vsync();
    int pulses = 0;
    do_commit();
    do_write(4'd7, 8'hFF, 1'b0);
    vsync = 1'b0;
    repeat (100) begin
      tick();
      if (swap_done === 1'b1) pulses++;
    end
    vsync = 1'b1;
    disp = staged;
    m_idle = 1'b1;
    total++;
    if (pulses !== 1) $display("FAIL held_vsync_swaps got %0d exp 1", pulses);
    else passed++;
    rd_addr = 4'd7;
    @(negedge clk);
    total++;
    if (rd_data !== 8'h00 || rd_data !== disp[7]) $display("FAIL blocked_rd7 got %h exp 00", rd_data);
    else passed++;
    total++;
    if ({wr_ready, pending} !== 2'b10) $display("FAIL blocked_flags got %b exp 10", {wr_ready, pending});
    else passed++;
  endtask
  task automatic test_reset_mid_copy();
    int pulses = 0;
    do_write(4'd9, 8'h99, 1'b1);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      if (swap_done === 1'b1) pulses++;
      total++;
      if (rd_data !== 8'h00) $display("FAIL midcopy_rd[%0d] got %h exp 00", i, rd_data);
      else passed++;
    end
    total++;
    if (pulses !== 0) $display("FAIL midcopy_swapdone got %0d pulses exp 0", pulses);
    else passed++;
    total++;
    if ({wr_ready, pending} !== 2'b10) $display("FAIL midcopy_flags got %b exp 10", {wr_ready, pending});
    else passed++;
  endtask
  task automatic test_random();
    int lat, nw;
    for (int it = 0; it < 6; it++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++)
        do_write(4'($urandom_range(0, 15)), 8'($urandom), (w == nw - 1) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1 && m_idle) begin
        do_swap(lat);
        total++;
        if (lat !== -1) $display("FAIL rand_idle_vsync it%0d got swap at %0d exp none", it, lat);
        else passed++;
      end
      if (m_idle) do_commit();
      rd_addr = 4'($urandom_range(0, 15));
      @(negedge clk);
      total++;
      if (rd_data !== disp[rd_addr]) $display("FAIL rand_preswap it%0d rd[%0d] got %h exp %h", it, rd_addr, rd_data, disp[rd_addr]);
      else passed++;
      do_swap(lat);
      total++;
      if (lat !== 16) $display("FAIL rand_latency it%0d got %0d exp 16", it, lat);
      else passed++;
      for (int i = 0; i < 16; i++) begin
        rd_addr = 4'(i);
        @(negedge clk);
        total++;
        if (rd_data !== disp[i]) $display("FAIL rand_rd it%0d [%0d] got %h exp %h", it, i, rd_data, disp[i]);
        else passed++;
      end
    end
  endtask
  initial begin
    test_reset();
    test_write_no_commit();
    test_commit_swap();
    test_mirror();
    test_blocked_and_held_vsync();
    test_reset_mid_copy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
